ledwalker_multi: RTL and testbench



---
 rtl/ledwalker_pkg.sv | 17 +
 rtl/ledwalker_strobe.sv | 36 +++
 rtl/ledwalker_multi.sv | 149 ++++++++++++++
 tb/tb_ledwalker_multi.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ledwalker_pkg.sv
// Shared walk-mode and direction encodings for the LED walker.
// Imported by ledwalker_strobe and ledwalker_multi.
package ledwalker_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROT_L  = 2'd1,
    MODE_ROT_R  = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/ledwalker_strobe.sv
// Free-running down counter that emits a registered one-cycle strobe
// every STEP_CLOCKS cycles; reusable timebase for board-level blocks.
module ledwalker_strobe #(
  parameter int STEP_CLOCKS = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_stb
);

  localparam int CW = $clog2(STEP_CLOCKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CLOCKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt   <= CNT_MAX;
      o_stb <= 1'b0;
    end else begin
      o_stb <= (cnt == '0);
      cnt   <= (cnt == '0) ? CNT_MAX : cnt - 1'b1;
    end
  end

`ifdef LEDWALKER_FORMAL_EN
  a_cnt_range: assert property (
    @(posedge i_clk) disable iff (i_reset)
    cnt <= CNT_MAX);

  a_stb_src: assert property (
    @(posedge i_clk) disable iff (i_reset)
    o_stb |-> ($past(cnt) == '0));
`endif

endmodule

// File: rtl/ledwalker_multi.sv
// Multi-mode one-hot LED walker (bounce / rotate left / rotate right / hold).
// Define LEDWALKER_FORMAL_EN to compile in the checking properties.
module ledwalker_multi
  import ledwalker_pkg::*;
#(
  parameter int NLEDS       = 8,
  parameter int CLK_RATE_HZ = 12_000_000,
  parameter int STEP_HZ     = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_mode_stb,
  input  logic [1:0]       i_mode,
  output logic [NLEDS-1:0] o_led,
  output logic             o_step,
  output logic [1:0]       o_mode
);

  localparam int STEP_CLOCKS = CLK_RATE_HZ / STEP_HZ;
  localparam int PW = $clog2(NLEDS);
  localparam logic [PW-1:0] POS_MAX = PW'(NLEDS - 1);
  localparam logic [NLEDS-1:0] LED_ONE = NLEDS'(1);

  logic stb;

  ledwalker_strobe #(
    .STEP_CLOCKS (STEP_CLOCKS)
  ) u_strobe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_stb   (stb)
  );

  mode_t         mode_q;
  mode_t         pend_q;
  mode_t         mode_eff;
  logic          pend_vld;
  logic [PW-1:0] pos_q;
  logic [PW-1:0] pos_d;
  dir_t          dir_q;
  dir_t          dir_d;

  // A pending request takes effect on the very step that consumes it.
  assign mode_eff = (stb && pend_vld) ? pend_q : mode_q;
  assign o_mode   = mode_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mode_q   <= MODE_BOUNCE;
      pend_q   <= MODE_BOUNCE;
      pend_vld <= 1'b0;
    end else begin
      if (stb)
        mode_q <= mode_eff;
      if (i_mode_stb) begin
        pend_q   <= mode_t'(i_mode);
        pend_vld <= 1'b1;
      end else if (stb) begin
        pend_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (stb) begin
      unique case (mode_eff)
        MODE_BOUNCE: begin
          if (pos_q == POS_MAX) begin
            pos_d = pos_q - 1'b1;
            dir_d = DIR_DOWN;
          end else if (pos_q == '0) begin
            pos_d = pos_q + 1'b1;
            dir_d = DIR_UP;
          end else if (dir_q == DIR_UP) begin
            pos_d = pos_q + 1'b1;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
        MODE_ROT_L: begin
          pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
          dir_d = DIR_UP;
        end
        MODE_ROT_R: begin
          pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
          dir_d = DIR_DOWN;
        end
        MODE_HOLD: begin
          pos_d = pos_q;
          dir_d = dir_q;
        end
      endcase
    end
  end

  // LEDs decode the next position so they land with o_step.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      o_led  <= LED_ONE;
      o_step <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      o_led  <= LED_ONE << pos_d;
      o_step <= stb;
    end
  end

`ifdef LEDWALKER_FORMAL_EN
  int unsigned gap;
  logic        seen;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      gap  <= 0;
      seen <= 1'b0;
    end else if (o_step) begin
      gap  <= 1;
      seen <= 1'b1;
    end else begin
      gap <= gap + 1;
    end
  end

  a_onehot: assert property (
    @(posedge i_clk) disable iff (i_reset)
    $onehot(o_led));

  a_pos_range: assert property (
    @(posedge i_clk) disable iff (i_reset)
    pos_q <= POS_MAX);

  a_no_skip: assert property (
    @(posedge i_clk) disable iff (i_reset)
    (o_step && mode_q == MODE_BOUNCE &&
     $past(mode_q) == MODE_BOUNCE) |->
    (o_led == ($past(o_led) << 1) ||
     o_led == ($past(o_led) >> 1)));

  a_step_gap: assert property (
    @(posedge i_clk) disable iff (i_reset)
    (o_step && seen) |-> gap == STEP_CLOCKS);
`endif

endmodule

// File: tb/tb_ledwalker_multi.sv
// Self-checking bench for ledwalker_multi: directed scenarios plus random
// mode requests and resets against a step-level behavioural model.
module tb_ledwalker_multi;

  localparam int NLEDS = 4;
  localparam int CLK_RATE_HZ = 4;
  localparam int STEP_HZ = 1;
  localparam int S = CLK_RATE_HZ / STEP_HZ;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b0;
  logic             i_mode_stb = 1'b0;
  logic [1:0]       i_mode = 2'd0;
  logic [NLEDS-1:0] o_led;
  logic             o_step;
  logic [1:0]       o_mode;

  always #5 i_clk = ~i_clk;

  ledwalker_multi #(
    .NLEDS       (NLEDS),
    .CLK_RATE_HZ (CLK_RATE_HZ),
    .STEP_HZ     (STEP_HZ)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_mode_stb (i_mode_stb),
    .i_mode     (i_mode),
    .o_led      (o_led),
    .o_step     (o_step),
    .o_mode     (o_mode)
  );

  int   checks = 0;
  int   errors = 0;
  int   n;
  int   m_pos, m_down, m_mode, m_pend, m_pv;
  logic exp_step;
  int   steps;

  function automatic logic [NLEDS-1:0] exp_led();
    return NLEDS'(1 << m_pos);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; m_pos = 0; m_down = 0;
    m_mode = 0; m_pend = 0; m_pv = 0;
    exp_step = 1'b0;
  endtask

  // One LED step from the walk rules, after loading any pending mode.
  task automatic model_step();
    if (m_pv != 0) begin
      m_mode = m_pend;
      m_pv = 0;
    end
    case (m_mode)
      0: begin
        if (m_pos == NLEDS - 1) begin
          m_pos = m_pos - 1; m_down = 1;
        end else if (m_pos == 0) begin
          m_pos = 1; m_down = 0;
        end else begin
          m_pos = m_down ? m_pos - 1 : m_pos + 1;
        end
      end
      1: begin m_pos = (m_pos + 1) % NLEDS; m_down = 0; end
      2: begin m_pos = (m_pos + NLEDS - 1) % NLEDS; m_down = 1; end
      default: ;
    endcase
  endtask

  task automatic tick(input logic req, input logic [1:0] m);
    i_mode_stb = req;
    i_mode = m;
    @(posedge i_clk);
    n++;
    // First step lands S+1 edges after release, then every S edges.
    exp_step = (n > S) && ((n - 1) % S == 0);
    if (exp_step) model_step();
    if (req) begin
      m_pend = int'(m);
      m_pv = 1;
    end
    #1;
    check("led", 32'(o_led), 32'(exp_led()));
    check("step", 32'(o_step), 32'(exp_step));
    check("mode", 32'(o_mode), 32'(m_mode));
    i_mode_stb = 1'b0;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 2'd0);
  endtask

  task automatic wait_led(input logic [NLEDS-1:0] tgt, input string tag);
    for (int k = 0; k < 64 && exp_led() != tgt; k++) tick(1'b0, 2'd0);
    check(tag, 32'(o_led), 32'(tgt));
  endtask

  // Called 1 time unit after a rising edge; stays clear of the next edge.
  task automatic pulse_reset();
    #2 i_reset = 1'b1;
    #1;
    model_reset();
    check("rst_led", 32'(o_led), 32'd1);
    check("rst_mode", 32'(o_mode), 32'd0);
    check("rst_step", 32'(o_step), 32'd0);
    #2 i_reset = 1'b0;
  endtask

  initial begin
    #1 i_reset = 1'b1;
    #1;
    model_reset();
    check("init_led", 32'(o_led), 32'd1);
    check("init_mode", 32'(o_mode), 32'd0);
    check("init_step", 32'(o_step), 32'd0);
    #9 i_reset = 1'b0;

    // Free-running bounce from reset.
    steps = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 2'd0);
      if (n == S) check("pre_first", 32'(o_led), 32'd1);
      if (n == S + 1) check("first_chg", 32'(o_led), 32'd2);
      if (o_step === 1'b1) steps++;
    end
    check("step_count", 32'(steps), 32'd7);

    // Bounce -> rotate left at LED 4.
    wait_led(4'd4, "wait4");
    tick(1'b1, 2'd1);
    check("rotl_not_yet", 32'(o_mode), 32'd0);
    run(20);

    // Rotate right from LED 1, then bounce at LED 4 keeps going down.
    wait_led(4'd1, "wait1");
    tick(1'b1, 2'd2);
    wait_led(4'd4, "wait4b");
    tick(1'b1, 2'd0);
    run(20);

    // Hold for several steps, then resume bounce.
    tick(1'b1, 2'd3);
    run(16);
    tick(1'b1, 2'd0);
    run(12);

    // Two requests before one step: last one wins.
    for (int k = 0; k < S && ((n - 1) % S) != 0; k++) tick(1'b0, 2'd0);
    tick(1'b1, 2'd1);
    tick(1'b1, 2'd2);
    run(10);
    check("last_wins", 32'(o_mode), 32'd2);

    // Request on the strobe cycle goes to the following step.
    for (int k = 0; k < S && (n % S) != 0; k++) tick(1'b0, 2'd0);
    tick(1'b1, 2'd3);
    check("stb_req_late", 32'(o_mode), 32'd2);
    run(S);
    check("stb_req_next", 32'(o_mode), 32'd3);

    // Reset mid-step at LED 8.
    tick(1'b1, 2'd0);
    wait_led(4'd8, "wait8");
    run(2);
    pulse_reset();
    run(S);
    check("post_rst_hold", 32'(o_led), 32'd1);
    run(1);
    check("post_rst_chg", 32'(o_led), 32'd2);

    // Random mode requests and occasional resets.
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) pulse_reset();
      else tick(r < 20, 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
